// File: rtl/xoodyak_digest_collector_pkg.sv
// Shared XOODYAK digest constants and the collector FSM state type.
package xoodyak_digest_collector_pkg;

  localparam int XDK_DIGEST_BYTES = 32;
  localparam int XDK_BYTE_W       = 8;
  localparam int XDK_DIGEST_W     = XDK_DIGEST_BYTES * XDK_BYTE_W;

  typedef enum logic [2:0] {
    COL_IDLE    = 3'd0,
    COL_ARMED   = 3'd1,
    COL_COLLECT = 3'd2,
    COL_DONE    = 3'd3
  } col_state_t;

endpackage

// File: rtl/xoodyak_digest_collector_if.sv
// Byte-serial digest stream from the XOODYAK core to the collector.
interface xoodyak_digest_collector_if;
  // hash is consumed on every rising edge where hash_valid is high; there is no
  // ready/backpressure, so the sink must accept one byte per valid cycle.
  // hash_len is only meaningful alongside the first byte of a digest.
  logic [7:0] hash;
  logic       hash_valid;
  logic [7:0] hash_len;

  modport master (output hash, output hash_valid, output hash_len);
  modport slave  (input  hash, input  hash_valid, input  hash_len);
endinterface

// File: rtl/xoodyak_digest_collector.sv
// Captures a byte-serial XOODYAK digest, compares it to an armed expectation and
// reports completion, match/mismatch, length error, overrun and timeout.
module xoodyak_digest_collector
  import xoodyak_digest_collector_pkg::*;
#(
    parameter int  DIGEST_BYTES   = XDK_DIGEST_BYTES,
    parameter int  TIMEOUT_CYCLES = 4096,
    parameter int  CNT_W          = 6,
    localparam int DIGEST_W       = 8 * DIGEST_BYTES
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  arm,
    input  logic [DIGEST_W-1:0]   exp_digest,
    xoodyak_digest_collector_if.slave hash_if,
    output logic [DIGEST_W-1:0]   digest,
    output logic                  digest_valid,
    output logic                  match,
    output logic                  mismatch,
    output logic                  len_err,
    output logic                  overrun,
    output logic                  timeout,
    output logic                  busy,
    output logic [CNT_W-1:0]      byte_cnt,
    output col_state_t            dbg_state
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGEST_BYTES - 1);
    localparam logic [7:0]       LEN_OK   = 8'(DIGEST_BYTES);

    col_state_t          state_q;
    logic [DIGEST_W-1:0] digest_q;
    logic [DIGEST_W-1:0] exp_q;
    logic [CNT_W-1:0]    byte_cnt_q;
    logic [TMR_W-1:0]    timer_q;
    logic                digest_valid_q;
    logic                match_q;
    logic                mismatch_q;
    logic                len_err_q;
    logic                overrun_q;
    logic                timeout_q;
    logic                busy_q;
    logic                armed_once_q;

    logic [DIGEST_W-1:0] digest_d;
    logic                collecting;
    logic                last_byte;
    logic                timer_expired;

    assign digest_d      = {digest_q[DIGEST_W-9:0], hash_if.hash};
    assign collecting    = (state_q == COL_ARMED) || (state_q == COL_COLLECT);
    assign last_byte     = hash_if.hash_valid && (byte_cnt_q == CNT_LAST);
    assign timer_expired = (timer_q == TMR_LAST);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= COL_IDLE;
            digest_q       <= '0;
            exp_q          <= '0;
            byte_cnt_q     <= '0;
            timer_q        <= '0;
            digest_valid_q <= 1'b0;
            match_q        <= 1'b0;
            mismatch_q     <= 1'b0;
            len_err_q      <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            armed_once_q   <= 1'b0;
        end else begin
            digest_valid_q <= 1'b0;
            // arm wins over everything, including a byte arriving in the same cycle.
            if (arm) begin
                state_q      <= COL_ARMED;
                exp_q        <= exp_digest;
                digest_q     <= '0;
                byte_cnt_q   <= '0;
                timer_q      <= '0;
                match_q      <= 1'b0;
                mismatch_q   <= 1'b0;
                len_err_q    <= 1'b0;
                overrun_q    <= 1'b0;
                timeout_q    <= 1'b0;
                busy_q       <= 1'b1;
                armed_once_q <= 1'b1;
            end else begin
                unique case (state_q)
                    COL_IDLE: begin
                        if (hash_if.hash_valid && armed_once_q) overrun_q <= 1'b1;
                    end
                    COL_ARMED, COL_COLLECT: begin
                        if (hash_if.hash_valid) begin
                            digest_q   <= digest_d;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            if ((state_q == COL_ARMED) && (hash_if.hash_len != LEN_OK))
                                len_err_q <= 1'b1;
                        end
                        // A completing byte on the final timer cycle still counts as success.
                        if (last_byte) begin
                            state_q        <= COL_DONE;
                            digest_valid_q <= 1'b1;
                            match_q        <= (digest_d == exp_q);
                            mismatch_q     <= (digest_d != exp_q);
                            busy_q         <= 1'b0;
                        end else if (timer_expired) begin
                            state_q   <= COL_IDLE;
                            timeout_q <= 1'b1;
                            busy_q    <= 1'b0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                            if (hash_if.hash_valid) state_q <= COL_COLLECT;
                        end
                    end
                    COL_DONE: begin
                        state_q <= COL_IDLE;
                        if (hash_if.hash_valid) overrun_q <= 1'b1;
                    end
                    default: begin
                        state_q <= COL_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;
    assign match        = match_q;
    assign mismatch     = mismatch_q;
    assign len_err      = len_err_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;
    assign byte_cnt     = byte_cnt_q;
    assign dbg_state    = state_q;

    logic unused_ok;
    assign unused_ok = collecting;

endmodule
